tpu_sequencer: RTL and testbench

- Parametrised phase sequencer driving the systolic array datapath through LOAD -> EXEC -> DRAIN for one tile operation.
- Each phase length and the memory base address are run-time configurable and latched on start. Zero-length phases are skipped.
- Generates the weight/activation memory address, per-phase enables, a busy flag, and done/aborted pulses.
- Sits between the RISC-V command interface and the array/memory blocks.

---
 rtl/tpu_sequencer.sv | 115 +++++++++++
 tb/tb_tpu_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tpu_sequencer.sv
// Phase sequencer for one systolic-array tile: LOAD -> EXEC -> DRAIN, zero-length phases skipped.
// Config is latched on start; outputs are Moore-decoded from state, counter and latched config.
module tpu_sequencer #(
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [CNT_W-1:0]  cfg_load_len,
   input  logic [CNT_W-1:0]  cfg_exec_len,
   input  logic [CNT_W-1:0]  cfg_drain_len,
   output logic              load_en,
   output logic              exec_en,
   output logic              drain_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   // state   | meaning
   // IDLE    | waiting for start (abort blocks start)
   // LOAD    | streaming operands, mem_addr = base + cnt
   // EXEC    | array computing
   // DRAIN   | results shifting out
   // DONE    | one-cycle completion pulse
   // ABORT   | one-cycle abort pulse
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_EXEC, S_DRAIN, S_DONE, S_ABORT
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  load_len, exec_len, drain_len;
   logic [ADDR_W-1:0] base;
   logic [CNT_W-1:0]  phase_len;
   logic              last_cyc;

   function automatic state_t first_phase(input logic [CNT_W-1:0] l,
                                          input logic [CNT_W-1:0] e,
                                          input logic [CNT_W-1:0] d);
      state_t s;
      if (l != '0)      s = S_LOAD;
      else if (e != '0) s = S_EXEC;
      else if (d != '0) s = S_DRAIN;
      else              s = S_DONE;
      return s;
   endfunction

   always_comb begin
      phase_len = '0;
      case (state)
         S_LOAD:  phase_len = load_len;
         S_EXEC:  phase_len = exec_len;
         S_DRAIN: phase_len = drain_len;
         default: phase_len = '0;
      endcase
   end

   assign last_cyc = (cnt == phase_len - CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         base      <= '0;
         load_len  <= '0;
         exec_len  <= '0;
         drain_len <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  base      <= cfg_base;
                  load_len  <= cfg_load_len;
                  exec_len  <= cfg_exec_len;
                  drain_len <= cfg_drain_len;
                  cnt       <= '0;
                  state     <= first_phase(cfg_load_len, cfg_exec_len, cfg_drain_len);
               end
            end
            S_LOAD, S_EXEC, S_DRAIN: begin
               if (abort) begin
                  cnt   <= '0;
                  state <= S_ABORT;
               end else if (last_cyc) begin
                  cnt <= '0;
                  // only later phases are candidates for the next one
                  case (state)
                     S_LOAD:  state <= first_phase('0, exec_len, drain_len);
                     S_EXEC:  state <= first_phase('0, '0, drain_len);
                     default: state <= S_DONE;
                  endcase
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DONE, S_ABORT: state <= S_IDLE;
            default:         state <= S_IDLE;
         endcase
      end
   end

   assign load_en  = (state == S_LOAD);
   assign exec_en  = (state == S_EXEC);
   assign drain_en = (state == S_DRAIN);
   assign done     = (state == S_DONE);
   assign aborted  = (state == S_ABORT);
   assign busy     = (state != S_IDLE);
   assign mem_addr = load_en ? (base + ADDR_W'(cnt)) : '0;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer: table of tile operations plus hand-written abort/reset sequences.
module tb_tpu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] cfg_base = '0;
   logic [4:0] cfg_load_len = '0;
   logic [4:0] cfg_exec_len = '0;
   logic [4:0] cfg_drain_len = '0;
   logic       load_en, exec_en, drain_en, busy, done, aborted;
   logic [3:0] mem_addr;

   int n_chk = 0;
   int n_err = 0;

   tpu_sequencer #(.ADDR_W(4), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_base(cfg_base), .cfg_load_len(cfg_load_len),
      .cfg_exec_len(cfg_exec_len), .cfg_drain_len(cfg_drain_len),
      .load_en(load_en), .exec_en(exec_en), .drain_en(drain_en),
      .mem_addr(mem_addr), .busy(busy), .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   // packed view: {busy, load_en, exec_en, drain_en, done, aborted, mem_addr}
   function automatic logic [9:0] obs();
      return {busy, load_en, exec_en, drain_en, done, aborted, mem_addr};
   endfunction

   function automatic logic [9:0] pk(input logic b, input logic l, input logic e,
                                     input logic d, input logic dn, input logic ab,
                                     input logic [3:0] a);
      return {b, l, e, d, dn, ab, a};
   endfunction

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got b/l/e/d/dn/ab/addr=%b required %b", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] base;
      logic [4:0] l;
      logic [4:0] e;
      logic [4:0] d;
      int         exp_done;    // hand-computed cycle of done after the start edge
      bit         hold_start;  // keep start high while busy (must be ignored)
   } vec_t;

   vec_t vecs[7];

   // Cycle k (1-based after start edge): phases occupy consecutive windows, done at exp_done.
   task automatic run_op(input int idx, input vec_t v);
      int t_load, t_exec, t_all;
      logic [9:0] exp;
      t_load = int'(v.l);
      t_exec = t_load + int'(v.e);
      t_all  = t_exec + int'(v.d);
      @(negedge clk);
      cfg_base = v.base; cfg_load_len = v.l; cfg_exec_len = v.e; cfg_drain_len = v.d;
      start = 1'b1; abort = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = v.hold_start;
      cfg_base = ~v.base; cfg_load_len = v.l ^ 5'h15; cfg_exec_len = v.e ^ 5'h0A;
      cfg_drain_len = v.d ^ 5'h1F;
      for (int k = 1; k <= v.exp_done + 1; k++) begin
         exp = pk(k <= v.exp_done,
                  k <= t_load,
                  k > t_load && k <= t_exec,
                  k > t_exec && k <= t_all,
                  k == v.exp_done,
                  1'b0,
                  (k <= t_load) ? 4'(int'(v.base) + k - 1) : 4'd0);
         check($sformatf("vec%0d cyc%0d", idx, k), obs(), exp);
         if (k == v.exp_done) start = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      vecs[0] = '{base: 4'd2,  l: 5'd4,  e: 5'd10, d: 5'd3, exp_done: 18, hold_start: 1'b0};
      vecs[1] = '{base: 4'd14, l: 5'd4,  e: 5'd0,  d: 5'd0, exp_done: 5,  hold_start: 1'b0}; // addr 14,15,0,1
      vecs[2] = '{base: 4'd0,  l: 5'd0,  e: 5'd5,  d: 5'd0, exp_done: 6,  hold_start: 1'b1};
      vecs[3] = '{base: 4'd5,  l: 5'd0,  e: 5'd0,  d: 5'd0, exp_done: 1,  hold_start: 1'b0};
      vecs[4] = '{base: 4'd9,  l: 5'd1,  e: 5'd1,  d: 5'd1, exp_done: 4,  hold_start: 1'b1};
      vecs[5] = '{base: 4'd15, l: 5'd31, e: 5'd0,  d: 5'd2, exp_done: 34, hold_start: 1'b0};
      vecs[6] = '{base: 4'd3,  l: 5'd0,  e: 5'd0,  d: 5'd7, exp_done: 8,  hold_start: 1'b1};

      repeat (3) @(negedge clk);
      check("in reset", obs(), '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("first cycle after reset", obs(), '0);

      for (int i = 0; i < 7; i++) run_op(i, vecs[i]);

      // reset in the middle of EXEC
      @(negedge clk);
      cfg_base = 4'd2; cfg_load_len = 5'd4; cfg_exec_len = 5'd10; cfg_drain_len = 5'd3;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("mid exec before reset", obs(), pk(1, 0, 1, 0, 0, 0, 4'd0));
      rst_n = 1'b0;
      #1;
      check("async reset immediate", obs(), '0);
      @(negedge clk);
      check("reset held 1", obs(), '0);
      @(negedge clk);
      check("reset held 2", obs(), '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle after reset release", obs(), '0);
      run_op(10, vecs[0]);

      // abort on the 3rd EXEC cycle with start held throughout
      @(negedge clk);
      cfg_base = 4'd0; cfg_load_len = 5'd3; cfg_exec_len = 5'd8; cfg_drain_len = 5'd2;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int k = 1; k <= 6; k++) begin
         check($sformatf("abort seq cyc%0d", k), obs(),
               pk(1, k <= 3, k > 3, 0, 0, 0, (k <= 3) ? 4'(k - 1) : 4'd0));
         if (k == 6) abort = 1'b1;
         @(negedge clk);
      end
      check("aborted pulse", obs(), pk(1, 0, 0, 0, 0, 1, 4'd0));
      abort = 1'b0;
      start = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         check($sformatf("post abort idle %0d", k), obs(), '0);
      end

      // start blocked by abort in IDLE
      start = 1'b1; abort = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("start blocked %0d", k), obs(), '0);
      end
      start = 1'b0; abort = 1'b0;
      run_op(20, vecs[2]);

      // abort during DONE is ignored
      @(negedge clk);
      cfg_base = 4'd0; cfg_load_len = 5'd0; cfg_exec_len = 5'd0; cfg_drain_len = 5'd1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("drain single", obs(), pk(1, 0, 0, 1, 0, 0, 4'd0));
      @(negedge clk);
      abort = 1'b1;
      check("done despite abort", obs(), pk(1, 0, 0, 0, 1, 0, 4'd0));
      @(negedge clk);
      check("idle after done, no aborted", obs(), '0);
      abort = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
